tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Top-level sequencer for the 32x32x3, 16-filter convolution engine. Loads the stationary weights once per `start`, then walks every output tile: it fires the IFM address generator, counts its streamed beats, waits out systolic-array drain and hands each finished tile to the OFM writer. It sits between the host/control interface and the IFM/weight address generators, systolic array and OFM write path.

## Interface
Parameters:
- `KERNEL_SIZE`, 3, kernel width/height
- `IFM_SIZE`, 34, padded IFM width/height
- `IFM_CHANNEL`, 3, input channels
- `NUM_FILTER`, 16, filters (array columns)
- `TILE_WIDTH`, 16, output pixels per tile
- `DRAIN_CYCLES`, 31, array flush cycles after last IFM beat

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin one full layer pass
- `wgt_load`  out  1  one-cycle pulse to the weight address generator
- `wgt_addr_valid`  in  1  weight beat strobe
- `ifm_load`  out  1  one-cycle pulse to the IFM address generator
- `ifm_addr_valid`  in  1  IFM beat strobe
- `sa_en`  out  1  systolic array shift enable
- `ofm_req`  out  1  tile result ready for write-out
- `ofm_ack`  in  1  OFM writer accepted tile
- `tile_idx`  out  7  current tile index
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last tile acknowledged
- `err`  out  1  sticky: beat strobe outside its expected state
- `perf_cycles`  out  32  cycles of last pass (see Configuration)

## Operation
- Constants: `OFM_SIZE = IFM_SIZE-KERNEL_SIZE+1` (32); `NUM_TILES = OFM_SIZE*OFM_SIZE/TILE_WIDTH` (64); `BURST_LEN = KERNEL_SIZE*KERNEL_SIZE*IFM_CHANNEL` (27); `WGT_LEN = BURST_LEN*NUM_FILTER` (432).
- States: IDLE, WGT_ISSUE, WGT_STREAM, IFM_ISSUE, IFM_STREAM, DRAIN, WRITE, DONE.
- IDLE: `start`=1 -> WGT_ISSUE; clears `tile_idx`, beat counter, `err`.
- WGT_ISSUE: `wgt_load`=1 one cycle -> WGT_STREAM.
- WGT_STREAM: count `wgt_addr_valid` beats; at WGT_LEN -> IFM_ISSUE.
- IFM_ISSUE: `ifm_load`=1 one cycle -> IFM_STREAM.
- IFM_STREAM: `sa_en`=1; count `ifm_addr_valid` beats; at BURST_LEN -> DRAIN.
- DRAIN: `sa_en`=1; down-counter DRAIN_CYCLES to 0 -> WRITE.
- WRITE: `ofm_req`=1, held until `ofm_ack`; on ack: `tile_idx`==NUM_TILES-1 -> DONE, else `tile_idx`+1 -> IFM_ISSUE.
- DONE: `done`=1 one cycle -> IDLE.
- Beat counter 10 bits, cleared on each ISSUE state. `tile_idx` wraps to 0 only via IDLE.
- `start` outside IDLE ignored. `ofm_ack` outside WRITE ignored.
- `wgt_addr_valid` outside WGT_STREAM, or `ifm_addr_valid` outside IFM_STREAM, sets `err`; no state effect. Cleared only by reset or accepted `start`.
- `busy` = state != IDLE.

## Timing
- Reset: state IDLE; all outputs 0; `tile_idx`=0; `perf_cycles`=0.
- All outputs registered-state decodes; no combinational input-to-output path.
- `start` sampled cycle N -> `wgt_load` high cycle N+1, `busy` high from N+1.
- Last counted beat in cycle M -> next state at M+1 (no overshoot; beat M+1 counted as error if still streaming).
- DRAIN lasts exactly DRAIN_CYCLES cycles; `ofm_req` rises the following cycle.
- `ofm_ack` same cycle `ofm_req` rises is valid: one-cycle WRITE.
- Per-tile minimum: 1 + BURST_LEN + DRAIN_CYCLES + 1 = 60 cycles.
- Reset mid-pass: immediate IDLE, pending pulses dropped.

## Configuration
- `TILE_SCHED_PERF_EN` defined: 32-bit counter clears on accepted `start`, increments each `busy` cycle, freezes at DONE; `perf_cycles` shows last value, saturates at all-ones.
- Not defined: counter absent, `perf_cycles` tied 0.

## Structure
- Shared package `sa_cfg_pkg`: state enum, `OFM_SIZE`, `NUM_TILES`, `BURST_LEN`, `WGT_LEN`, derived widths.
- One sub-module `beat_counter` (clear, enable, terminal-count compare), instanced for weight/IFM beats and drain; FSM stays in `tile_scheduler`.

## Test plan
- Nominal pass, 1-cycle-late ack, generator models emitting 432 then 27 beats/tile -> 64 `ofm_req`, one `done`, `tile_idx` 0..63, `err`=0.
- `ofm_ack` held high constantly -> each WRITE 1 cycle; tile period exactly 60 cycles.
- `start` pulsed in IFM_STREAM of tile 5 -> ignored, `tile_idx` continues 6.
- Extra 28th `ifm_addr_valid` beat -> `err`=1 sticky, tile count unaffected; next `start` clears it.
- `rst_n` low during DRAIN of tile 10 -> outputs 0 immediately, state IDLE, `tile_idx`=0.
- With `TILE_SCHED_PERF_EN`, ack after 3 cycles each tile -> `perf_cycles` equals measured busy length.

Source files
------------

// File: rtl/sa_cfg_pkg.sv
// Shared configuration for the 32x32x3, 16-filter convolution engine sequencer.
// Holds default layer geometry, derived tile/burst constants, counter widths,
// the scheduler state encoding and a saturating-increment helper.
package sa_cfg_pkg;

    // Default layer geometry
    localparam int KERNEL_SIZE_DEF  = 3;
    localparam int IFM_SIZE_DEF     = 34;
    localparam int IFM_CHANNEL_DEF  = 3;
    localparam int NUM_FILTER_DEF   = 16;
    localparam int TILE_WIDTH_DEF   = 16;
    localparam int DRAIN_CYCLES_DEF = 31;

    // Derived constants for the default geometry
    localparam int OFM_SIZE  = IFM_SIZE_DEF - KERNEL_SIZE_DEF + 1;                 // 32
    localparam int NUM_TILES = OFM_SIZE * OFM_SIZE / TILE_WIDTH_DEF;               // 64
    localparam int BURST_LEN = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF * IFM_CHANNEL_DEF; // 27
    localparam int WGT_LEN   = BURST_LEN * NUM_FILTER_DEF;                         // 432

    // Derived widths
    localparam int BEAT_W     = 10;
    localparam int TILE_IDX_W = 7;
    localparam int PERF_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WGT_ISSUE  = 3'd1,
        ST_WGT_STREAM = 3'd2,
        ST_IFM_ISSUE  = 3'd3,
        ST_IFM_STREAM = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_WRITE      = 3'd6,
        ST_DONE       = 3'd7
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Control bundle between tile_scheduler and its environment (host, address
// generators, systolic array, OFM writer). master = scheduler side,
// slave = environment side. No storage; pure wiring.
interface tile_scheduler_if;
    import sa_cfg_pkg::*;

    logic                  start;
    logic                  wgt_load;
    logic                  wgt_addr_valid;
    logic                  ifm_load;
    logic                  ifm_addr_valid;
    logic                  sa_en;
    logic                  ofm_req;
    logic                  ofm_ack;
    logic [TILE_IDX_W-1:0] tile_idx;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [PERF_W-1:0]     perf_cycles;

    modport master (
        input  start, wgt_addr_valid, ifm_addr_valid, ofm_ack,
        output wgt_load, ifm_load, sa_en, ofm_req, tile_idx, busy, done, err,
               perf_cycles
    );

    modport slave (
        output start, wgt_addr_valid, ifm_addr_valid, ofm_ack,
        input  wgt_load, ifm_load, sa_en, ofm_req, tile_idx, busy, done, err,
               perf_cycles
    );

endinterface

// File: rtl/beat_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count strobe.
// Latency: tc is combinational on en in the cycle the last event is counted.
// Backpressure: none; counts every enabled cycle.
// Ports: clk, rst_n, clr (zero the count), en (count this cycle),
//        last (terminal value), tc (en && count == last).
module beat_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Fires on the event that completes the run, so the owner can leave its
    // state on the following edge without overshooting.
    assign tc = en && (cnt_q == last);

endmodule

// File: rtl/tile_scheduler.sv
// Sequencer for the convolution engine: loads weights once per start, then
// per output tile fires the IFM generator, counts its beats, waits out array
// drain and hands the tile to the OFM writer.
// Latency: start sampled in N -> wgt_load/busy in N+1; tile period >= 60 cycles.
// Backpressure: holds ofm_req until ofm_ack; beat strobes are counted, never stalled.
// Ports: clk, rst_n (async active-low), bus (tile_scheduler_if.master):
//   start, wgt_load/wgt_addr_valid, ifm_load/ifm_addr_valid, sa_en,
//   ofm_req/ofm_ack, tile_idx, busy, done, err (sticky), perf_cycles.
// Optional: define TILE_SCHED_PERF_EN to build the pass-length cycle counter;
// without it perf_cycles is tied to zero.
module tile_scheduler
    import sa_cfg_pkg::*;
#(
    parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
    parameter int IFM_SIZE     = IFM_SIZE_DEF,
    parameter int IFM_CHANNEL  = IFM_CHANNEL_DEF,
    parameter int NUM_FILTER   = NUM_FILTER_DEF,
    parameter int TILE_WIDTH   = TILE_WIDTH_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    tile_scheduler_if.master bus
);

    localparam int OFM_DIM   = IFM_SIZE - KERNEL_SIZE + 1;
    localparam int TILES     = OFM_DIM * OFM_DIM / TILE_WIDTH;
    localparam int BURST     = KERNEL_SIZE * KERNEL_SIZE * IFM_CHANNEL;
    localparam int WGT_BEATS = BURST * NUM_FILTER;

    localparam logic [BEAT_W-1:0]     WGT_LAST   = BEAT_W'(WGT_BEATS - 1);
    localparam logic [BEAT_W-1:0]     IFM_LAST   = BEAT_W'(BURST - 1);
    localparam logic [BEAT_W-1:0]     DRAIN_LAST = BEAT_W'(DRAIN_CYCLES - 1);
    localparam logic [TILE_IDX_W-1:0] TILE_LAST  = TILE_IDX_W'(TILES - 1);

    sched_state_t state_q, state_d;

    logic                  start_acc;
    logic                  beat_clr, beat_en, beat_tc;
    logic [BEAT_W-1:0]     beat_last;
    logic                  drain_tc;
    logic                  last_tile;
    logic                  stray_beat;
    logic [TILE_IDX_W-1:0] tile_idx_q;
    logic                  err_q;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign last_tile = (tile_idx_q == TILE_LAST);

    // One counter serves both streams: they never overlap and each ISSUE
    // state zeroes it before its stream begins.
    assign beat_clr  = start_acc || (state_q == ST_WGT_ISSUE) || (state_q == ST_IFM_ISSUE);
    assign beat_en   = ((state_q == ST_WGT_STREAM) && bus.wgt_addr_valid) ||
                       ((state_q == ST_IFM_STREAM) && bus.ifm_addr_valid);
    assign beat_last = (state_q == ST_WGT_STREAM) ? WGT_LAST : IFM_LAST;

    beat_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (beat_clr),
        .en    (beat_en),
        .last  (beat_last),
        .tc    (beat_tc)
    );

    // Drain timer: held at zero outside DRAIN, so DRAIN lasts exactly
    // DRAIN_CYCLES cycles (counts 0..DRAIN_CYCLES-1).
    beat_counter #(.W(BEAT_W)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_DRAIN),
        .en    (state_q == ST_DRAIN),
        .last  (DRAIN_LAST),
        .tc    (drain_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (bus.start) state_d = ST_WGT_ISSUE;
            ST_WGT_ISSUE:  state_d = ST_WGT_STREAM;
            ST_WGT_STREAM: if (beat_tc) state_d = ST_IFM_ISSUE;
            ST_IFM_ISSUE:  state_d = ST_IFM_STREAM;
            ST_IFM_STREAM: if (beat_tc) state_d = ST_DRAIN;
            ST_DRAIN:      if (drain_tc) state_d = ST_WRITE;
            ST_WRITE:      if (bus.ofm_ack) state_d = last_tile ? ST_DONE : ST_IFM_ISSUE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Output decode: every strobe is a function of the state register only.
    always_comb begin
        bus.wgt_load = 1'b0;
        bus.ifm_load = 1'b0;
        bus.sa_en    = 1'b0;
        bus.ofm_req  = 1'b0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_WGT_ISSUE:  bus.wgt_load = 1'b1;
            ST_IFM_ISSUE:  bus.ifm_load = 1'b1;
            ST_IFM_STREAM: bus.sa_en    = 1'b1;
            ST_DRAIN:      bus.sa_en    = 1'b1;
            ST_WRITE:      bus.ofm_req  = 1'b1;
            ST_DONE:       bus.done     = 1'b1;
            default:       ;
        endcase
    end

    // Tile index: cleared only when a new pass is accepted, advanced on each
    // acknowledged tile except the last, so it reads NUM_TILES-1 after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_idx_q <= '0;
        end else if (start_acc) begin
            tile_idx_q <= '0;
        end else if ((state_q == ST_WRITE) && bus.ofm_ack && !last_tile) begin
            tile_idx_q <= tile_idx_q + TILE_IDX_W'(1);
        end
    end

    // A beat strobe arriving while its stream is not open is a generator
    // protocol fault; it is flagged but never moves the FSM.
    assign stray_beat = (bus.wgt_addr_valid && (state_q != ST_WGT_STREAM)) ||
                        (bus.ifm_addr_valid && (state_q != ST_IFM_STREAM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if (stray_beat) begin
            err_q <= 1'b1;
        end
    end

    assign bus.tile_idx = tile_idx_q;
    assign bus.err      = err_q;

`ifdef TILE_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_run_q;
    logic [PERF_W-1:0] perf_last_q;

    // perf_run_q counts busy cycles of the pass in flight; the DONE cycle
    // itself is folded in when the total is published, so perf_cycles
    // equals the full number of cycles busy was high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_run_q  <= '0;
            perf_last_q <= '0;
        end else begin
            if (start_acc) begin
                perf_run_q <= '0;
            end else if (state_q != ST_IDLE) begin
                perf_run_q <= sat_inc(perf_run_q);
            end
            if (state_q == ST_DONE) begin
                perf_last_q <= sat_inc(perf_run_q);
            end
        end
    end

    assign bus.perf_cycles = perf_last_q;
`else
    assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Table-driven bench for tile_scheduler: each row runs one layer pass against
// simple weight/IFM generator and OFM writer models and checks the outcome;
// reset state and start timing are checked by hand-written sequences.
module tb_tile_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tile_scheduler_if bus ();

    tile_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int ack_delay;   // extra cycles ofm_req is held before ack
        bit ack_always;  // ofm_ack tied high for the whole pass
        int start_tile;  // tile whose IFM stream gets a stray start (-1 none)
        int extra_tile;  // tile whose generator emits a 28th beat (-1 none)
        int rst_tile;    // tile whose drain is cut by reset (-1 none)
        bit exp_err;     // err expected after the pass
        bit chk_period;  // check 60-cycle tile period
    } vec_t;

    vec_t vecs[6];

    localparam int BUDGET = 8000;

    task automatic drive_idle();
        bus.start          = 1'b0;
        bus.wgt_addr_valid = 1'b0;
        bus.ifm_addr_valid = 1'b0;
        bus.ofm_ack        = 1'b0;
    endtask

    task automatic run_pass(input int row, input vec_t v);
        int  wgt_rem = 0, ifm_rem = 0, req_run = 0, sa_run = 0;
        int  exp_tile = 0, reqs = 0, dones = 0, wloads = 0, iloads = 0;
        int  busy_len = 0, last_rise = -1;
        bit  prev_req = 1'b0, injected = 1'b0, aborted = 1'b0, finished = 1'b0;
        string tag;
        tag = $sformatf("row%0d", row);

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " start->wgt_load"}, 64'(bus.wgt_load), 64'd1);
        check({tag, " start->busy"},     64'(bus.busy),     64'd1);
        check({tag, " start clears err"}, 64'(bus.err),     64'd0);
        check({tag, " start clears tile_idx"}, 64'(bus.tile_idx), 64'd0);

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (bus.busy)     busy_len++;
            if (bus.wgt_load) wloads++;
            if (bus.ifm_load) iloads++;
            if (bus.done)     dones++;
            if (bus.ofm_req && !prev_req) begin
                check($sformatf("%s tile_idx at req %0d", tag, exp_tile),
                      64'(bus.tile_idx), 64'(exp_tile));
                if (v.chk_period && last_rise >= 0)
                    check($sformatf("%s tile period %0d", tag, exp_tile),
                          64'(cyc - last_rise), 64'd60);
                last_rise = cyc;
                exp_tile++;
                reqs++;
            end
            prev_req = bus.ofm_req;

            if (bus.sa_en) sa_run++; else sa_run = 0;

            // Reset well inside the drain window of the chosen tile.
            if (v.rst_tile >= 0 && int'(bus.tile_idx) == v.rst_tile && sa_run == 40) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst busy"},     64'(bus.busy),     64'd0);
                check({tag, " rst sa_en"},    64'(bus.sa_en),    64'd0);
                check({tag, " rst ofm_req"},  64'(bus.ofm_req),  64'd0);
                check({tag, " rst tile_idx"}, 64'(bus.tile_idx), 64'd0);
                check({tag, " rst loads"},    64'({bus.wgt_load, bus.ifm_load, bus.done}), 64'd0);
                check({tag, " rst perf"},     64'(bus.perf_cycles), 64'd0);
                check({tag, " rst no done"},  64'(dones), 64'd0);
                aborted = 1'b1;
                break;
            end

            // Generator models: beats start the cycle after the load pulse.
            bus.wgt_addr_valid = (wgt_rem > 0);
            if (wgt_rem > 0) wgt_rem--;
            if (bus.wgt_load) wgt_rem = 432;
            bus.ifm_addr_valid = (ifm_rem > 0);
            if (ifm_rem > 0) ifm_rem--;
            if (bus.ifm_load) ifm_rem = (int'(bus.tile_idx) == v.extra_tile) ? 28 : 27;

            if (v.ack_always) begin
                bus.ofm_ack = 1'b1;
            end else begin
                if (bus.ofm_req) req_run++; else req_run = 0;
                bus.ofm_ack = bus.ofm_req && (req_run > v.ack_delay);
            end

            bus.start = 1'b0;
            if (!injected && int'(bus.tile_idx) == v.start_tile && ifm_rem > 0 && ifm_rem < 27) begin
                bus.start = 1'b1;
                injected  = 1'b1;
            end

            if (dones > 0) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end

        if (aborted) begin
            drive_idle();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check({tag, " idle after rst"}, 64'(bus.busy), 64'd0);
            return;
        end

        if (!finished) begin
            check({tag, " pass timeout"}, 64'(finished), 64'd1);
            drive_idle();
            return;
        end

        drive_idle();
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check({tag, " ofm_req count"}, 64'(reqs),   64'd64);
        check({tag, " done count"},    64'(dones),  64'd1);
        check({tag, " wgt_load count"}, 64'(wloads), 64'd1);
        check({tag, " ifm_load count"}, 64'(iloads), 64'd64);
        check({tag, " err"},           64'(bus.err), 64'(v.exp_err));
        check({tag, " busy after done"}, 64'(bus.busy), 64'd0);
        check({tag, " final tile_idx"}, 64'(bus.tile_idx), 64'd63);
`ifdef TILE_SCHED_PERF_EN
        check({tag, " perf_cycles"}, 64'(bus.perf_cycles), 64'(busy_len));
`else
        check({tag, " perf_cycles tied"}, 64'(bus.perf_cycles), 64'd0);
`endif
    endtask

    initial begin
        vecs[0] = '{ack_delay: 1, ack_always: 1'b0, start_tile: -1, extra_tile: -1, rst_tile: -1, exp_err: 1'b0, chk_period: 1'b0};
        vecs[1] = '{ack_delay: 0, ack_always: 1'b1, start_tile: -1, extra_tile: -1, rst_tile: -1, exp_err: 1'b0, chk_period: 1'b1};
        vecs[2] = '{ack_delay: 0, ack_always: 1'b0, start_tile: 5,  extra_tile: -1, rst_tile: -1, exp_err: 1'b0, chk_period: 1'b0};
        vecs[3] = '{ack_delay: 3, ack_always: 1'b0, start_tile: -1, extra_tile: 2,  rst_tile: -1, exp_err: 1'b1, chk_period: 1'b0};
        vecs[4] = '{ack_delay: 2, ack_always: 1'b0, start_tile: -1, extra_tile: -1, rst_tile: 10, exp_err: 1'b0, chk_period: 1'b0};
        vecs[5] = '{ack_delay: 1, ack_always: 1'b0, start_tile: -1, extra_tile: -1, rst_tile: -1, exp_err: 1'b0, chk_period: 1'b0};

        drive_idle();

        // Reset state
        @(negedge clk);
        check("reset busy",     64'(bus.busy),     64'd0);
        check("reset tile_idx", 64'(bus.tile_idx), 64'd0);
        check("reset strobes",  64'({bus.wgt_load, bus.ifm_load, bus.sa_en, bus.ofm_req, bus.done, bus.err}), 64'd0);
        check("reset perf",     64'(bus.perf_cycles), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray ack and beat strobes in IDLE: no state effect, beat sets err.
        @(negedge clk);
        bus.ofm_ack = 1'b1;
        bus.ifm_addr_valid = 1'b1;
        @(negedge clk);
        drive_idle();
        check("idle stray busy", 64'(bus.busy), 64'd0);
        check("idle stray err",  64'(bus.err),  64'd1);

        for (int r = 0; r < 6; r++) begin
            run_pass(r, vecs[r]);
            repeat (2) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
